// File: rtl/casez_state_seq.sv
// casez_state_seq -- run-sequence controller producing the 3-bit state code
// read by a downstream casez decoder (000/001 -> 1, 01?/1?? -> 0).
//
// Sequence: IDLE -> ARM -> RUN_A/RUN_B alternating for RUN_LEN unheld
// cycles -> DONE -> IDLE. An abort in ARM/RUN goes through ABORT, and an
// optional hold watchdog goes through TIMEOUT. Illegal codes recover to IDLE
// and set the sticky error flag.
//
// Optional feature: define CASEZ_STATE_SEQ_WDOG_EN to build the hold
// watchdog (8-bit consecutive-hold counter, TIMEOUT after WDOG_MAX held
// cycles). When it is not defined, hold may freeze RUN indefinitely and code
// 110 is recovered like an illegal code.
//
// Parameters:
//   RUN_LEN   non-held RUN cycles per sequence (2..256)
//   WDOG_MAX  consecutive held RUN cycles before timeout (1..255)
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  sequence request, sampled only in IDLE
//   abort_i  abandon sequence, honoured in ARM and RUN
//   hold_i   freeze RUN progress while high
//   state_o  registered state code
//   busy_o   high in ARM, RUN_A, RUN_B
//   done_o   high exactly while state_o is DONE
//   err_o    sticky error, cleared by the next accepted start
module casez_state_seq #(
  parameter int RUN_LEN  = 8,
  parameter int WDOG_MAX = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       hold_i,
  output logic [2:0] state_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CW = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(RUN_LEN - 1);

  if (RUN_LEN < 2 || RUN_LEN > 256) begin : g_bad_run_len
    $error("casez_state_seq: RUN_LEN must be in 2..256");
  end
  if (WDOG_MAX < 1 || WDOG_MAX > 255) begin : g_bad_wdog_max
    $error("casez_state_seq: WDOG_MAX must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_ARM     = 3'b001,
    S_RUN_A   = 3'b010,
    S_RUN_B   = 3'b011,
    S_DONE    = 3'b100,
    S_ABORT   = 3'b101,
    S_TIMEOUT = 3'b110
  } state_e;

  // Kept as a plain 3-bit vector so every code, including 111, is
  // representable and recoverable.
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

`ifdef CASEZ_STATE_SEQ_WDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_MAX);
  logic [7:0] hcnt_q, hcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef CASEZ_STATE_SEQ_WDOG_EN
    hcnt_d  = hcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ARM;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef CASEZ_STATE_SEQ_WDOG_EN
          hcnt_d  = '0;
`endif
        end
      end
      S_ARM: begin
        if (abort_i) begin
          state_d = S_ABORT;
          err_d   = 1'b1;
        end else begin
          state_d = S_RUN_A;
        end
      end
      S_RUN_A, S_RUN_B: begin
        if (abort_i) begin
          state_d = S_ABORT;
          err_d   = 1'b1;
        end else if (hold_i) begin
          // Held: state and run counter frozen.
`ifdef CASEZ_STATE_SEQ_WDOG_EN
          if (hcnt_q == WDOG_LIM) begin
            state_d = S_TIMEOUT;
            err_d   = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
          end
`endif
        end else begin
`ifdef CASEZ_STATE_SEQ_WDOG_EN
          hcnt_d = '0;
`endif
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (state_q == S_RUN_A) ? S_RUN_B : S_RUN_A;
          end
        end
      end
      S_DONE, S_ABORT: state_d = S_IDLE;
`ifdef CASEZ_STATE_SEQ_WDOG_EN
      S_TIMEOUT: state_d = S_IDLE;
`endif
      default: begin
        // 111 always, and 110 when the watchdog is not built.
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    endcase

    // Decoded from the next state so the flag flops change on the same
    // edge as state_q.
    busy_d = (state_d == S_ARM) || (state_d == S_RUN_A) || (state_d == S_RUN_B);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CASEZ_STATE_SEQ_WDOG_EN
      hcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CASEZ_STATE_SEQ_WDOG_EN
      hcnt_q  <= hcnt_d;
`endif
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule
